// File: rtl/text_console_pkg.sv
// Shared definitions for the text console engine: CI command codes, FSM states
// and the control characters the engine interprets.
// Latency: n/a (definitions only). Backpressure: n/a.
package text_console_pkg;

  // Custom-instruction command codes, carried in ciDataA[3:0].
  localparam logic [3:0] CMD_PUTC           = 4'd0;
  localparam logic [3:0] CMD_SET_ATTR       = 4'd1;
  localparam logic [3:0] CMD_CLEAR          = 4'd2;
  localparam logic [3:0] CMD_SET_CURSOR     = 4'd3;
  localparam logic [3:0] CMD_SET_CURSOR_VIS = 4'd4;
  localparam logic [3:0] CMD_READ_ATTR      = 4'd8;
  localparam logic [3:0] CMD_READ_STATUS    = 4'd9;
  localparam logic [3:0] CMD_READ_GEOMETRY  = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLR_SCREEN,
    CLR_LINE
  } stateT;

  localparam logic [6:0] CH_LF    = 7'h0A;
  localparam logic [6:0] CH_CR    = 7'h0D;
  localparam logic [6:0] CH_BS    = 7'h08;
  localparam logic [6:0] CH_TAB   = 7'h09;
  localparam logic [6:0] CH_FF    = 7'h0C;
  localparam logic [6:0] CH_SPACE = 7'h20;

  function automatic logic isPrintable(input logic [6:0] c);
    return (c >= 7'h20) && (c <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_console_fifo.sv
// Synchronous character FIFO; combinational read of the head entry.
// Latency: pushed entry is visible at popData the cycle after the push.
// Backpressure: push ignored when full unless a pop frees the slot that same cycle.
// Ports: clock, reset (sync, active-low), flush, push/pushData, pop/popData,
//        full, empty, level (entry count).
module text_console_fifo
  import text_console_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/text_console_engine.sv
// Text console write engine: CI commands -> char FIFO -> control-char interpreter -> screen RAM writes, ring-buffer scrolling.
// Latency: PUTC/reads/CLEAR ack in the accepting cycle; a queued char reaches ramWe 2 cycles after it is pushed into an idle engine.
// Backpressure: PUTC on a full FIFO and SET_ATTR/SET_CURSOR/SET_CURSOR_VIS hold ciDone off until they can complete.
// Ports: clock, reset (sync, active-low); ciN/ciDataA/ciDataB/ciStart/ciCke in,
//        ciDone/ciResult out; ramWe/ramAddress/ramData to the screen RAM;
//        screenBase, cursorX, cursorY, cursorVisible to the display side.
// Build option: define TEXT_CONSOLE_ATTR_EN to get the attribute register
//   (SET_ATTR/READ_ATTR functional); otherwise ramData[15:8] is 8'h00.
module text_console_engine
  import text_console_pkg::*;
#(
  parameter logic [7:0] CI_NR        = 8'd0,
  parameter int         COLS         = 80,
  parameter int         ROWS         = 45,
  parameter int         FIFO_DEPTH   = 16,
  parameter int         ADDR_W       = 13,
  parameter int         TAB_WIDTH    = 8,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        ciN,
  input  logic [31:0]       ciDataA,
  input  logic [31:0]       ciDataB,
  input  logic              ciStart,
  input  logic              ciCke,
  output logic              ciDone,
  output logic [31:0]       ciResult,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [15:0]       ramData,
  output logic [ADDR_W-1:0] screenBase,
  output logic [6:0]        cursorX,
  output logic [6:0]        cursorY,
  output logic              cursorVisible
);

  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam int SCREEN = COLS * ROWS;
  localparam int SLAST  = SCREEN - 1;
  localparam int LASTX  = COLS - 1;
  localparam int LASTY  = ROWS - 1;
  localparam int TM     = TAB_WIDTH - 1;
  localparam logic [ADDR_W:0]   SCREEN_E    = SCREEN[ADDR_W:0];
  localparam logic [ADDR_W-1:0] SCREEN_LAST = SLAST[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] COLS_A      = COLS[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LASTX_A     = LASTX[ADDR_W-1:0];
  localparam logic [6:0]        LASTX7      = LASTX[6:0];
  localparam logic [6:0]        LASTY7      = LASTY[6:0];
  localparam logic [6:0]        COLS7       = COLS[6:0];
  localparam logic [6:0]        ROWS7       = ROWS[6:0];
  localparam logic [7:0]        COLS8       = COLS[7:0];
  localparam logic [7:0]        TABM8       = TM[7:0];

  // Address add modulo the screen size; both operands are already < SCREEN.
  function automatic logic [ADDR_W-1:0] wrapAdd(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SCREEN_E) s = s - SCREEN_E;
    return s[ADDR_W-1:0];
  endfunction

  stateT             state;
  logic [ADDR_W-1:0] base, rowPtr, clrCnt;
  logic [6:0]        x, y, rebuildCnt, curChar;
  logic              vis, pend, rebuilding;
  logic [3:0]        pendCmd;
  logic [31:0]       pendOp;
  logic [7:0]        attrOut;

`ifdef TEXT_CONSOLE_ATTR_EN
  logic [7:0] attr;
  assign attrOut = attr;
`else
  assign attrOut = 8'h00;
`endif

  logic          fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [LW-1:0] fifoLevel;
  logic [6:0]    fifoPopData;

  logic [3:0] cmd;
  logic       ciHit, clearNow, idleEmpty, slotFree, hitDeferred, pendDone, busy;
  logic [6:0] clampX, clampY;
  logic       unusedBits;

  assign cmd       = ciDataA[3:0];
  // A new command is only taken once the previous one has been acked.
  assign ciHit     = reset && ciStart && ciCke && (ciN == CI_NR) && !pend;
  assign clearNow  = ciHit && (cmd == CMD_CLEAR);
  assign idleEmpty = (state == IDLE) && fifoEmpty;
  assign fifoPop   = reset && (state == IDLE) && !fifoEmpty && !clearNow;
  assign slotFree  = !fifoFull || fifoPop;
  assign fifoPush  = reset && slotFree &&
                     ((ciHit && cmd == CMD_PUTC) || (pend && pendCmd == CMD_PUTC));
  assign hitDeferred = (cmd == CMD_SET_ATTR) || (cmd == CMD_SET_CURSOR) ||
                       (cmd == CMD_SET_CURSOR_VIS) || (cmd == CMD_PUTC && !slotFree);
  assign pendDone  = reset && pend &&
                     ((pendCmd == CMD_PUTC)       ? slotFree :
                      (pendCmd == CMD_SET_CURSOR) ? (rebuilding && rebuildCnt == 7'd0) :
                                                    idleEmpty);
  assign ciDone    = (ciHit && !hitDeferred) || pendDone;
  assign busy      = (state != IDLE) || !fifoEmpty;
  assign clampX    = (pendOp[6:0]   > LASTX7) ? LASTX7 : pendOp[6:0];
  assign clampY    = (pendOp[22:16] > LASTY7) ? LASTY7 : pendOp[22:16];
  assign unusedBits = ^{ciDataA[31:4], pendOp[31:23], pendOp[15:7]};

  assign screenBase    = base;
  assign cursorX       = x;
  assign cursorY       = y;
  assign cursorVisible = vis;

  always_comb begin
    ciResult = 32'd0;
    if (ciHit) begin
      case (cmd)
        CMD_READ_ATTR:     ciResult = {24'd0, attrOut};
        CMD_READ_STATUS:   ciResult = {busy, 15'd0, 16'(fifoLevel)};
        CMD_READ_GEOMETRY: ciResult = {9'd0, ROWS7, 9'd0, COLS7};
        default:           ciResult = 32'd0;
      endcase
    end
  end

  // Decode of the character being executed.
  logic              nl, doWrite, goClr;
  logic [6:0]        nextX, wrChar;
  logic [ADDR_W-1:0] wrAt;
  logic [7:0]        tabX;

  always_comb begin
    nl      = 1'b0;
    doWrite = 1'b0;
    goClr   = 1'b0;
    nextX   = x;
    wrChar  = CH_SPACE;
    wrAt    = wrapAdd(rowPtr, ADDR_W'(x));
    tabX    = ({1'b0, x} | TABM8) + 8'd1;
    if (isPrintable(curChar)) begin
      doWrite = 1'b1;
      wrChar  = curChar;
      if (x == LASTX7) begin
        nextX = 7'd0;
        nl    = 1'b1;
      end else begin
        nextX = x + 7'd1;
      end
    end else begin
      case (curChar)
        CH_LF: begin
          nextX = 7'd0;
          nl    = 1'b1;
        end
        CH_CR: nextX = 7'd0;
        CH_BS: if (x != 7'd0) begin
          nextX   = x - 7'd1;
          doWrite = 1'b1;
          wrAt    = wrapAdd(rowPtr, ADDR_W'(x - 7'd1));
        end
        CH_TAB: if (tabX >= COLS8) begin
          nextX = 7'd0;
          nl    = 1'b1;
        end else begin
          nextX = tabX[6:0];
        end
        CH_FF:   goClr = 1'b1;
        default: nextX = x;
      endcase
    end
  end

  text_console_fifo #(
    .WIDTH (7),
    .DEPTH (FIFO_DEPTH)
  ) charFifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (clearNow),
    .push     (fifoPush),
    .pushData (pend ? pendOp[6:0] : ciDataB[6:0]),
    .pop      (fifoPop),
    .popData  (fifoPopData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifoLevel)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= CLR_SCREEN;
      clrCnt     <= '0;
      base       <= '0;
      rowPtr     <= '0;
      x          <= 7'd0;
      y          <= 7'd0;
      vis        <= 1'b1;
      curChar    <= 7'd0;
      pend       <= 1'b0;
      pendCmd    <= 4'd0;
      pendOp     <= 32'd0;
      rebuilding <= 1'b0;
      rebuildCnt <= 7'd0;
      ramWe      <= 1'b0;
      ramAddress <= '0;
      ramData    <= 16'd0;
`ifdef TEXT_CONSOLE_ATTR_EN
      attr       <= DEFAULT_ATTR;
`endif
    end else begin
      ramWe <= 1'b0;
      case (state)
        IDLE: if (fifoPop) begin
          curChar <= fifoPopData;
          state   <= EXEC;
        end
        EXEC: begin
          if (goClr) begin
            clrCnt <= '0;
            state  <= CLR_SCREEN;
          end else begin
            x <= nextX;
            if (doWrite) begin
              ramWe      <= 1'b1;
              ramAddress <= wrAt;
              ramData    <= {attrOut, 1'b0, wrChar};
            end
            if (nl && y != LASTY7) begin
              y      <= y + 7'd1;
              rowPtr <= wrapAdd(rowPtr, COLS_A);
              state  <= IDLE;
            end else if (nl) begin
              // Scroll: the new bottom row sits where the old top row was.
              base   <= wrapAdd(base, COLS_A);
              rowPtr <= base;
              clrCnt <= '0;
              state  <= CLR_LINE;
            end else begin
              state <= IDLE;
            end
          end
        end
        CLR_SCREEN: begin
          ramWe      <= 1'b1;
          ramAddress <= clrCnt;
          ramData    <= {attrOut, 1'b0, CH_SPACE};
          if (clrCnt == SCREEN_LAST) begin
            clrCnt <= '0;
            x      <= 7'd0;
            y      <= 7'd0;
            base   <= '0;
            rowPtr <= '0;
            state  <= IDLE;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        CLR_LINE: begin
          ramWe      <= 1'b1;
          ramAddress <= wrapAdd(rowPtr, clrCnt);
          ramData    <= {attrOut, 1'b0, CH_SPACE};
          if (clrCnt == LASTX_A) begin
            clrCnt <= '0;
            state  <= IDLE;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (ciHit && hitDeferred) begin
        pend    <= 1'b1;
        pendCmd <= cmd;
        pendOp  <= ciDataB;
      end

      if (pend) begin
        case (pendCmd)
          CMD_PUTC: if (slotFree) pend <= 1'b0;
          CMD_SET_CURSOR: begin
            // rowPtr is rebuilt as base + y*COLS by y wrapped additions.
            if (!rebuilding) begin
              if (idleEmpty) begin
                x          <= clampX;
                y          <= clampY;
                rowPtr     <= base;
                rebuildCnt <= clampY;
                rebuilding <= 1'b1;
              end
            end else if (rebuildCnt != 7'd0) begin
              rowPtr     <= wrapAdd(rowPtr, COLS_A);
              rebuildCnt <= rebuildCnt - 7'd1;
            end else begin
              rebuilding <= 1'b0;
              pend       <= 1'b0;
            end
          end
          default: if (idleEmpty) begin
`ifdef TEXT_CONSOLE_ATTR_EN
            if (pendCmd == CMD_SET_ATTR) attr <= pendOp[7:0];
`endif
            if (pendCmd == CMD_SET_CURSOR_VIS) vis <= pendOp[0];
            pend <= 1'b0;
          end
        endcase
      end

      if (clearNow) begin
        clrCnt <= '0;
        state  <= CLR_SCREEN;
      end
    end
  end

endmodule

// File: tb/tb_text_console_engine.sv
// Directed self-checking bench for text_console_engine with an attached screen RAM model.
// Latency: n/a. Backpressure: exercised through a full character FIFO.
module tb_text_console_engine;

  localparam int ADDR_W = 13;

`ifdef TEXT_CONSOLE_ATTR_EN
  localparam logic [7:0] A0 = 8'h0F;
  localparam logic [7:0] A1 = 8'h1E;
`else
  localparam logic [7:0] A0 = 8'h00;
  localparam logic [7:0] A1 = 8'h00;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [7:0]        ciN;
  logic [31:0]       ciDataA, ciDataB;
  logic              ciStart, ciCke;
  logic              ciDone;
  logic [31:0]       ciResult;
  logic              ramWe;
  logic [ADDR_W-1:0] ramAddress;
  logic [15:0]       ramData;
  logic [ADDR_W-1:0] screenBase;
  logic [6:0]        cursorX, cursorY;
  logic              cursorVisible;

  logic [15:0] ram [0:8191];
  int          wrCount = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ramWe) begin
      ram[ramAddress] <= ramData;
      wrCount <= wrCount + 1;
    end
  end

  text_console_engine #(
    .CI_NR(8'd0), .COLS(80), .ROWS(45), .FIFO_DEPTH(16),
    .ADDR_W(ADDR_W), .TAB_WIDTH(8), .DEFAULT_ATTR(8'h0F)
  ) dut (
    .clock(clock), .reset(reset), .ciN(ciN), .ciDataA(ciDataA), .ciDataB(ciDataB),
    .ciStart(ciStart), .ciCke(ciCke), .ciDone(ciDone), .ciResult(ciResult),
    .ramWe(ramWe), .ramAddress(ramAddress), .ramData(ramData), .screenBase(screenBase),
    .cursorX(cursorX), .cursorY(cursorY), .cursorVisible(cursorVisible)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one CI command; returns the result and the cycles waited past acceptance.
  task automatic ciCall(input logic [3:0] cmd, input logic [31:0] op, input int limit,
                        output logic [31:0] res, output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    res = 32'd0;
    @(negedge clock);
    ciN = 8'd0; ciDataA = {28'd0, cmd}; ciDataB = op; ciStart = 1'b1;
    while (!got && lat <= limit) begin
      #2;
      if (ciDone) begin
        got = 1'b1;
        res = ciResult;
      end
      @(posedge clock);
      #1;
      ciStart = 1'b0;
      if (!got) begin
        lat++;
        @(negedge clock);
      end
    end
    if (!got) checkEq("ci_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic putc(input logic [7:0] ch, output int lat);
    logic [31:0] r;
    ciCall(4'd0, {24'd0, ch}, 5000, r, lat);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [31:0] r;
    int          lat, bad, doneSeen, w0;

    reset = 1'b0; ciN = 8'd0; ciDataA = 32'd0; ciDataB = 32'd0; ciStart = 1'b0; ciCke = 1'b1;
    waitCycles(3);
    #2;
    checkEq("rst_cursorX", {25'd0, cursorX}, 32'd0);
    checkEq("rst_cursorY", {25'd0, cursorY}, 32'd0);
    checkEq("rst_base", {19'd0, screenBase}, 32'd0);
    checkEq("rst_visible", {31'd0, cursorVisible}, 32'd1);
    checkEq("rst_ciResult", ciResult, 32'd0);

    // Power-up screen clear.
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 3610; i++) begin
      @(negedge clock);
      #2;
      if (ciDone) doneSeen++;
    end
    bad = 0;
    for (int a = 0; a < 3600; a++) if (ram[a] !== {A0, 8'h20}) bad++;
    checkEq("clr_ram_bad", bad, 0);
    checkEq("clr_done_pulses", doneSeen, 0);
    checkEq("clr_cursor", {cursorX, cursorY}, 14'd0);

    ciCall(4'd15, 32'd0, 10, r, lat);
    checkEq("geometry", r, 32'h002D0050);
    checkEq("geometry_lat", lat, 0);
    ciCall(4'd9, 32'd0, 10, r, lat);
    checkEq("status_idle", r, 32'd0);
    ciCall(4'd8, 32'd0, 10, r, lat);
    checkEq("attr_default", r, {24'd0, A0});
    ciCall(4'd5, 32'hFFFF_FFFF, 10, r, lat);
    checkEq("unknown_cmd_res", r, 32'd0);
    checkEq("unknown_cmd_lat", lat, 0);

    // 'A', LF, 'B'.
    putc(8'h41, lat);
    checkEq("putc_lat", lat, 0);
    putc(8'h0A, lat);
    putc(8'h42, lat);
    waitCycles(8);
    checkEq("ram0_A", ram[0], {A0, 8'h41});
    checkEq("ram80_B", ram[80], {A0, 8'h42});
    checkEq("cursor_after_B", {25'd0, cursorX}, 32'd1);
    checkEq("row_after_B", {25'd0, cursorY}, 32'd1);

    // TAB past the last stop wraps to the next line.
    ciCall(4'd3, {9'd0, 7'd1, 9'd0, 7'd78}, 500, r, lat);
    putc(8'h09, lat);
    waitCycles(6);
    checkEq("tab_wrap", {cursorX, cursorY}, {7'd0, 7'd2});
    putc(8'h43, lat);
    waitCycles(6);
    checkEq("ram160_C", ram[160], {A0, 8'h43});

    // CR and BS at column 0 write nothing; BS elsewhere erases.
    ciCall(4'd3, {9'd0, 7'd3, 9'd0, 7'd5}, 500, r, lat);
    w0 = wrCount;
    putc(8'h0D, lat);
    waitCycles(6);
    checkEq("cr_x", {25'd0, cursorX}, 32'd0);
    putc(8'h08, lat);
    waitCycles(6);
    checkEq("cr_bs_no_write", wrCount - w0, 0);
    checkEq("bs_x0", {25'd0, cursorX}, 32'd0);
    putc(8'h44, lat);
    putc(8'h08, lat);
    waitCycles(8);
    checkEq("bs_erase", ram[240], {A0, 8'h20});
    checkEq("bs_writes", wrCount - w0, 2);
    checkEq("bs_cursor", {cursorX, cursorY}, {7'd0, 7'd3});

    ciCall(4'd3, {9'd0, 7'd100, 9'd0, 7'd120}, 500, r, lat);
    checkEq("clamp", {cursorX, cursorY}, {7'd79, 7'd44});

    // Scroll via LF on the last row.
    ciCall(4'd3, {9'd0, 7'd44, 9'd0, 7'd0}, 500, r, lat);
    putc(8'h45, lat);
    putc(8'h0A, lat);
    waitCycles(100);
    checkEq("ram3520_E", ram[3520], {A0, 8'h45});
    bad = 0;
    for (int a = 0; a < 80; a++) if (ram[a] !== {A0, 8'h20}) bad++;
    checkEq("scroll_line_bad", bad, 0);
    checkEq("scroll_base", {19'd0, screenBase}, 32'd80);
    checkEq("scroll_cursor", {cursorX, cursorY}, {7'd0, 7'd44});
    putc(8'h46, lat);
    waitCycles(6);
    checkEq("ram0_F", ram[0], {A0, 8'h46});

    // Auto-wrap at the last column on the last row scrolls again.
    ciCall(4'd3, {9'd0, 7'd44, 9'd0, 7'd79}, 500, r, lat);
    putc(8'h47, lat);
    waitCycles(100);
    checkEq("ram79_G", ram[79], {A0, 8'h47});
    checkEq("ram80_cleared", ram[80], {A0, 8'h20});
    checkEq("wrap_base", {19'd0, screenBase}, 32'd160);
    checkEq("wrap_cursor", {cursorX, cursorY}, {7'd0, 7'd44});

    // FF starts a long clear; the FIFO fills and the 17th PUTC stalls.
    putc(8'h0C, lat);
    for (int i = 0; i < 16; i++) begin
      putc(8'h61 + 8'(i), lat);
      checkEq("burst_lat", lat, 0);
    end
    ciCall(4'd9, 32'd0, 10, r, lat);
    checkEq("status_full", r, 32'h8000_0010);
    putc(8'h71, lat);
    checkEq("putc17_delayed", {31'd0, lat > 1000}, 32'd1);
    for (int i = 17; i < 20; i++) putc(8'h61 + 8'(i), lat);
    waitCycles(80);
    bad = 0;
    for (int a = 0; a < 20; a++) if (ram[a] !== {A0, 8'h61 + 8'(a)}) bad++;
    checkEq("burst_order_bad", bad, 0);
    checkEq("burst_cursor", {cursorX, cursorY}, {7'd20, 7'd0});
    checkEq("ff_base", {19'd0, screenBase}, 32'd0);

    // Attribute path.
    ciCall(4'd1, 32'h0000_001E, 500, r, lat);
    putc(8'h5A, lat);
    waitCycles(6);
    checkEq("attr_Z", ram[20], {A1, 8'h5A});
    ciCall(4'd8, 32'd0, 10, r, lat);
    checkEq("attr_read", r, {24'd0, A1});

    ciCall(4'd4, 32'd0, 500, r, lat);
    checkEq("cursor_hidden", {31'd0, cursorVisible}, 32'd0);

    // CLEAR acks at once and stays busy until the clear finishes.
    ciCall(4'd2, 32'd0, 10, r, lat);
    checkEq("clear_lat", lat, 0);
    ciCall(4'd9, 32'd0, 10, r, lat);
    checkEq("clear_busy", {31'd0, r[31]}, 32'd1);
    waitCycles(3610);
    checkEq("clear_ram20", ram[20], {A1, 8'h20});
    ciCall(4'd9, 32'd0, 10, r, lat);
    checkEq("clear_done_status", r, 32'd0);

    // Reset mid-operation restores defaults and suppresses CI acks.
    ciCall(4'd3, {9'd0, 7'd5, 9'd0, 7'd10}, 500, r, lat);
    checkEq("setcur", {cursorX, cursorY}, {7'd10, 7'd5});
    @(negedge clock);
    reset = 1'b0;
    ciDataA = 32'd0; ciDataB = 32'h41; ciStart = 1'b1;
    #2;
    checkEq("rst_no_done", {31'd0, ciDone}, 32'd0);
    @(posedge clock);
    #1;
    ciStart = 1'b0;
    checkEq("rst2_cursor", {cursorX, cursorY}, 14'd0);
    checkEq("rst2_visible", {31'd0, cursorVisible}, 32'd1);
    checkEq("rst2_base", {19'd0, screenBase}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_console_engine.md
Name: text_console_engine

Overview:
- Parametrised successor to the HDMI text controller's write side.
- Accepts characters over a Nios custom-instruction (CI) interface and buffers them in a FIFO.
- Interprets control characters (LF, CR, BS, TAB, FF) and writes {attribute, char} words into the screen RAM.
- Maintains a ring-buffer scroll base so the display side reads the RAM with no copying; sits between the CPU CI port and the dual-port screen RAM.

Parameters:
- CI_NR, 8'd0: custom-instruction number this block answers to.
- COLS, 80: characters per line, 2..127.
- ROWS, 45: lines per screen, 2..127.
- FIFO_DEPTH, 16: character FIFO entries, power of 2.
- ADDR_W, 13: RAM address width; 2^ADDR_W >= COLS*ROWS.
- TAB_WIDTH, 8: tab stop spacing, power of 2.
- DEFAULT_ATTR, 8'h0F: attribute after reset; [7:4] background palette index, [3:0] foreground palette index.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low.
- ciN  in  8  CI number.
- ciDataA  in  32  command in [3:0].
- ciDataB  in  32  operand.
- ciStart  in  1  CI start, one-cycle pulse.
- ciCke  in  1  CI clock enable.
- ciDone  out  1  CI completion, one-cycle pulse.
- ciResult  out  32  read data; 0 unless a read command completes.
- ramWe  out  1  RAM write strobe.
- ramAddress  out  ADDR_W  RAM write address.
- ramData  out  16  {attr, 1'b0, char[6:0]}.
- screenBase  out  ADDR_W  RAM address of the top visible line, for the display side.
- cursorX  out  7  cursor column.
- cursorY  out  7  cursor row.
- cursorVisible  out  1  cursor enable.

Behaviour:
- Reset (reset==0 at a clock edge), values:
  - ciDone=0, ciResult=0, FIFO empty, attr=DEFAULT_ATTR.
  - cursorX=cursorY=0, screenBase=0, cursorVisible=1.
  - FSM enters CLR_SCREEN.
  - Reset mid-operation aborts everything, including a pending CI.
- CI acceptance: a command is accepted when ciN==CI_NR and ciStart and ciCke. The command and operand are latched, so ciStart need not be held.
- Commands (ciDataA[3:0]):
  - 0 PUTC: push B[6:0]. ciDone in the same cycle if the FIFO is not full. If full, ciDone fires the first cycle a slot frees, and the push happens that cycle.
  - 1 SET_ATTR: B[7:0].
  - 2 CLEAR: flush FIFO, then clear screen.
  - 3 SET_CURSOR: x=B[6:0], y=B[22:16], each clamped to COLS-1 / ROWS-1.
  - 4 SET_CURSOR_VIS: B[0].
  - 8 READ_ATTR.
  - 9 READ_STATUS: {busy, 15'd0, fifo_level[15:0]}.
  - 15 READ_GEOMETRY: {9'd0, ROWS[6:0], 9'd0, COLS[6:0]}.
  - Any other code: ack with no effect.
- Ordering:
  - Commands 1, 3 and 4 wait until the FIFO is empty and the FSM is IDLE, then apply and pulse ciDone.
  - CLEAR acks on acceptance; busy stays high until the clear completes.
  - Reads ack on acceptance, in the same cycle, with ciResult valid.
- FSM states IDLE, EXEC, CLR_SCREEN, CLR_LINE:
  - IDLE: when the FIFO is non-empty, pop one entry -> EXEC.
  - EXEC: one cycle.
  - CLR_SCREEN: writes space with the current attr to addresses 0..COLS*ROWS-1, one per cycle. Afterwards cursor=0,0 and base=0 -> IDLE.
  - CLR_LINE: writes COLS spaces at the new bottom row -> IDLE.
- EXEC character rules:
  - 0x20..0x7E: write at the cursor, then x++. At x==COLS-1 the write is followed by a newline.
  - LF 0x0A: x=0, newline.
  - CR 0x0D: x=0.
  - BS 0x08: if x>0, x-- and write space at the new x; if x==0, no-op.
  - TAB 0x09: x=(x|TAB_WIDTH-1)+1. If the result >= COLS, x=0 and newline. Nothing is written.
  - FF 0x0C: -> CLR_SCREEN.
  - Any other code: ignored.
- Newline:
  - If y<ROWS-1: y++.
  - Otherwise: base += COLS, wrapping modulo COLS*ROWS, then -> CLR_LINE.
- Addressing, no multipliers:
  - A rowPtr register tracks base + y*COLS modulo COLS*ROWS, updated by add/subtract with a wrap compare.
  - ramAddress = rowPtr + x, wrapped.
  - SET_CURSOR rebuilds rowPtr iteratively over y cycles before ciDone.
- ramWe is asserted only in EXEC writes, CLR_SCREEN and CLR_LINE. There is one write per cycle, with address and data registered with ramWe.
- Simultaneous events: a CI accepted in the same cycle as a pop is legal, and the FIFO supports push and pop in one cycle.

Optional Feature:
- Macro TEXT_CONSOLE_ATTR_EN.
- Defined: attr register present; ramData[15:8]=attr; SET_ATTR and READ_ATTR are functional.
- Undefined: no attr register; ramData[15:8]=8'h00; SET_ATTR acks with no effect; READ_ATTR returns 0.

Decomposition:
- Package text_console_pkg holds:
  - command code constants;
  - FSM state enum;
  - character constants LF, CR, BS, TAB, FF, SPACE.
- One sub-module, text_console_fifo: synchronous FIFO with parameters width 7 and FIFO_DEPTH, providing full, empty and level outputs.

Test Plan:
- Reset, then 45*80 cycles: RAM addresses 0..3599 all hold 16'h0F20; cursor 0,0; ciDone never pulsed.
- PUTC 'A' then LF then 'B': RAM[0]=16'h0F41, RAM[80]=16'h0F42, cursor (1,1).
- Fill 45 lines then LF on the last row: screenBase=80; RAM[0..79] cleared to 0F20; cursorY stays 44.
- 20 back-to-back PUTC with FIFO_DEPTH=16 while the FSM is busy: the 17th ciDone is delayed until the first pop; all 20 characters land in order.
- Cursor at x=78 with TAB_WIDTH=8: TAB gives x=0, y+1. BS at x=0: no write. CR at x=5: x=0, nothing written.
- SET_ATTR 8'h1E then PUTC 'Z': ramData=16'h1E5A with the macro defined, 16'h005A without; READ_GEOMETRY returns 32'h002D0050.
